// File: rtl/ir_fetch_unit.sv
// Instruction fetch unit: assembles little-endian 16-bit instructions from byte-wide memory and owns the PC.
// Optional wait-state watchdog enabled by defining FETCH_TIMEOUT_EN.
module ir_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Flush,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    output logic        MemRd,
    output logic [15:0] MemAddr,
    input  logic        MemValid,
    input  logic [7:0]  MemData,
    output logic [15:0] IROut,
    output logic        IRValid,
    output logic [15:0] PCOut,
    output logic        Busy,
    output logic        Fault
);

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] start_pc;
    logic        timeout_hit;

    assign MemRd   = (state != IDLE);
    assign MemAddr = pc;
    assign PCOut   = pc;
    assign Busy    = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       fault_r;

    // Abort fires on the TIMEOUT-th consecutive cycle without a byte
    assign timeout_hit = (state != IDLE) && !MemValid && (wait_cnt == 8'(TIMEOUT - 1));
    assign Fault       = fault_r;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= 8'd0;
            fault_r  <= 1'b0;
        end else begin
            fault_r <= timeout_hit && !Flush;
            if (state == IDLE || MemValid || Flush || timeout_hit)
                wait_cnt <= 8'd0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Fault       = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            start_pc <= RESET_PC;
            IROut    <= 16'h0000;
            IRValid  <= 1'b0;
        end else begin
            IRValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (PCLoad) begin
                        pc <= PCIn;
                    end else if (Start) begin
                        start_pc <= pc;
                        state    <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    // Abort (flush or timeout) rewinds to the instruction's first byte
                    if (Flush || timeout_hit) begin
                        pc    <= start_pc;
                        state <= IDLE;
                    end else if (MemValid) begin
                        IROut[7:0] <= MemData;
                        pc         <= pc + 16'd1;
                        state      <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (Flush || timeout_hit) begin
                        pc    <= start_pc;
                        state <= IDLE;
                    end else if (MemValid) begin
                        IROut[15:8] <= MemData;
                        pc          <= pc + 16'd1;
                        IRValid     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: byte memory model with programmable wait states and a scoreboard.
module tb_ir_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Flush;
    logic        PCLoad;
    logic [15:0] PCIn;
    logic        MemRd;
    logic [15:0] MemAddr;
    logic        MemValid;
    logic [7:0]  MemData;
    logic [15:0] IROut;
    logic        IRValid;
    logic [15:0] PCOut;
    logic        Busy;
    logic        Fault;

    int n_cmp = 0;
    int n_err = 0;

    ir_fetch_unit dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Flush   (Flush),
        .PCLoad  (PCLoad),
        .PCIn    (PCIn),
        .MemRd   (MemRd),
        .MemAddr (MemAddr),
        .MemValid(MemValid),
        .MemData (MemData),
        .IROut   (IROut),
        .IRValid (IRValid),
        .PCOut   (PCOut),
        .Busy    (Busy),
        .Fault   (Fault)
    );

    always #5 Clock = ~Clock;

    // Memory model: MemValid after ws wait cycles per byte, or never while stalled
    logic [7:0] mem [0:65535];
    int         ws    = 0;
    logic       stall = 1'b0;
    int         wcnt  = 0;

    assign MemValid = MemRd && !stall && (wcnt >= ws);
    assign MemData  = mem[MemAddr];

    always @(posedge Clock) begin
        if (!MemRd || MemValid) wcnt <= 0;
        else                    wcnt <= wcnt + 1;
    end

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t sbq[$];
    exp_t sb_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge Clock) begin
        if (IRValid) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_irvalid", 32'd1, 32'd0);
            end else begin
                sb_e = sbq.pop_front();
                check("sb_ir", IROut, sb_e.ir);
                check("sb_pc", PCOut, sb_e.pc);
            end
        end
        if (IRValid || Fault) check("irvalid_fault_excl", IRValid && Fault, 1'b0);
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        PCLoad = 1'b1;
        PCIn   = v;
        tick();
        PCLoad = 1'b0;
    endtask

    // One fetch from the current PC; checks latency and MemAddr per busy cycle
    task automatic fetch(input int exp_lat, input bit noise);
        logic [15:0] spc;
        logic [15:0] spc1;
        int lat;
        int k;
        spc  = PCOut;
        spc1 = spc + 16'd1;
        sbq.push_back({mem[spc1], mem[spc], 16'(spc + 16'd2)});
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0;
        k = 0;
        while (!IRValid && lat < 60) begin
            if (MemRd) begin
                check("memaddr", MemAddr, (k > ws) ? spc1 : spc);
                k++;
            end
            if (noise) begin
                PCLoad = 1'b1;
                PCIn   = 16'hBEEF;
                Start  = 1'b1;
            end
            tick();
            lat++;
        end
        PCLoad = 1'b0;
        Start  = 1'b0;
        check("latency", lat, exp_lat);
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] p1;
        logic [7:0]  hi;
        int          n;
        bit          saw;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        mem[16'h0020] = 8'h77;
        mem[16'h0021] = 8'h99;

        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; PCLoad = 1'b0; PCIn = 16'h0000;
        tick();
        tick();
        check("rst_pc", PCOut, 16'h0000);
        check("rst_ir", IROut, 16'h0000);
        check("rst_irvalid", IRValid, 1'b0);
        check("rst_memrd", MemRd, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_fault", Fault, 1'b0);
        Reset = 1'b1;
        tick();

        // Basic zero-wait fetch
        load_pc(16'h0010);
        check("pcload", PCOut, 16'h0010);
        fetch(2, 1'b0);
        check("t2_ir", IROut, 16'h1234);
        check("t2_pc", PCOut, 16'h0012);

        // Two wait states per byte
        load_pc(16'h0010);
        ws = 2;
        fetch(6, 1'b0);
        check("t3_ir", IROut, 16'h1234);
        ws = 0;

        // PCLoad/Start while busy must be ignored
        load_pc(16'h1234);
        ws = 3;
        fetch(8, 1'b1);
        check("busy_ignore_pc", PCOut, 16'h1236);
        ws = 0;

        // PCLoad beats Start, then wrap-around fetch
        PCLoad = 1'b1; PCIn = 16'hFFFF; Start = 1'b1;
        tick();
        PCLoad = 1'b0; Start = 1'b0;
        check("pcload_prio_busy", Busy, 1'b0);
        check("pcload_prio_pc", PCOut, 16'hFFFF);
        fetch(2, 1'b0);
        check("t4_ir", IROut, 16'hABCD);
        check("t4_pc", PCOut, 16'h0001);

        // Held Start: back-to-back fetches every 3 cycles
        load_pc(16'h0030);
        p  = PCOut;
        p1 = p + 16'd1;
        sbq.push_back({mem[p1], mem[p], 16'(p + 16'd2)});
        p  = p + 16'd2;
        p1 = p + 16'd1;
        sbq.push_back({mem[p1], mem[p], 16'(p + 16'd2)});
        Start = 1'b1;
        n = 0;
        while (!IRValid && n < 20) begin tick(); n++; end
        check("b2b_first", n, 3);
        n = 0;
        do begin tick(); n++; end while (!IRValid && n < 20);
        Start = 1'b0;
        check("b2b_period", n, 3);
        tick();

        // Flush in IDLE does nothing
        p = PCOut;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_idle_pc", PCOut, p);
        check("flush_idle_busy", Busy, 1'b0);

        // Flush in FETCH_HI with MemValid present
        load_pc(16'h0020);
        hi = IROut[15:8];
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("t5_addr_hi", MemAddr, 16'h0021);
        check("t5_memvalid", MemValid, 1'b1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("t5_irvalid", IRValid, 1'b0);
        check("t5_pc", PCOut, 16'h0020);
        check("t5_busy", Busy, 1'b0);
        check("t5_ir_hi", IROut[15:8], hi);
        check("t5_ir_lo", IROut[7:0], 8'h77);
        tick();
        check("t5_irvalid_late", IRValid, 1'b0);

        // Asynchronous reset in the middle of FETCH_HI
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("t1_in_hi_addr", MemAddr, 16'h0021);
        Reset = 1'b0;
        #2;
        check("t1_pc", PCOut, 16'h0000);
        check("t1_ir", IROut, 16'h0000);
        check("t1_memrd", MemRd, 1'b0);
        check("t1_busy", Busy, 1'b0);
        tick();
        Reset = 1'b1;
        tick();

        // Memory that never answers
        load_pc(16'h0040);
        stall = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        n = 0;
        while (!Fault && n < 40) begin tick(); n++; end
        check("t6_timeout_lat", n, 15);
        check("t6_pc", PCOut, 16'h0040);
        check("t6_busy", Busy, 1'b0);
        check("t6_irvalid", IRValid, 1'b0);
        tick();
        check("t6_fault_pulse", Fault, 1'b0);
`else
        saw = 1'b0;
        repeat (100) begin
            tick();
            if (Fault) saw = 1'b1;
        end
        check("t6_still_busy", Busy, 1'b1);
        check("t6_no_fault", saw, 1'b0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("t6_flush_pc", PCOut, 16'h0040);
        check("t6_flush_busy", Busy, 1'b0);
`endif
        stall = 1'b0;
        tick();

        // Normal operation resumes after abort
        ws = 1;
        fetch(4, 1'b0);
        check("resume_pc", PCOut, 16'h0042);
        ws = 0;
        tick();
        tick();
        check("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
